bits_req_sched: RTL and testbench

//  Round-robin scheduler and flow controller in front of the 32-bit-in / 15-bit-out bit FIFO (bits).

---
 rtl/bits_req_sched.sv | 150 +++++++++++++++
 tb/tb_bits_req_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bits_req_sched.sv
// rtl/bits_req_sched.sv - round-robin bit-request scheduler and flow controller for the bit FIFO
module bits_req_sched #(
  parameter int NREQ     = 4,
  parameter int CAP_BITS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  input  logic [31:0]       src_data,
  output logic              src_ready,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_len,
  output logic [NREQ-1:0]   req_ready,
  input  logic              hold,
  output logic              hold_ack,
  output logic              pushin,
  output logic [31:0]       datain,
  output logic              reqin,
  output logic [3:0]        reqlen,
  input  logic              pushout,
  input  logic [3:0]        lenout,
  input  logic [14:0]       dataout,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [3:0]        rsp_len,
  output logic [14:0]       rsp_data,
  output logic [10:0]       occ,
  output logic              err
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [10:0] PUSH_LIMIT = 11'(CAP_BITS - 32);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [10:0]     occ_q, occ_d;
  logic            t1_vld_q, t1_vld_d, t2_vld_q, t2_vld_d;
  logic [IDW-1:0]  t1_id_q, t1_id_d, t2_id_q, t2_id_d;
  logic [3:0]      t1_len_q, t1_len_d, t2_len_q, t2_len_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] eligible;
  logic            grant_vld;
  logic [IDW-1:0]  grant_id;
  int              arb_idx;

  // Source side: accept a word only if a full 32 bits of space remain
  assign src_ready = (occ_q <= PUSH_LIMIT);
  assign pushin    = src_valid & src_ready;
  assign datain    = src_data;

  // A requester may be granted only in RUN, without hold, and with enough buffered bits
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = (state_q == ST_RUN) && !hold && req_valid[i] &&
                    ({7'd0, req_len[4*i +: 4]} <= occ_q);
    end
  end

  // Round-robin search starting at rr_ptr; first eligible requester wins
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      arb_idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_vld && eligible[arb_idx]) begin
        grant_vld = 1'b1;
        grant_id  = IDW'(arb_idx);
      end
    end
  end

  // Grant strobes toward requesters and the FIFO read port
  always_comb begin
    req_ready = '0;
    if (grant_vld) req_ready[grant_id] = 1'b1;
  end

  assign reqin  = grant_vld;
  assign reqlen = grant_vld ? req_len[{grant_id, 2'b00} +: 4] : 4'd0;

  // Responses are steered by the tag that has aged two cycles, matching FIFO latency
  assign rsp_valid = (pushout && t2_vld_q) ? (NREQ'(1) << t2_id_q) : '0;
  assign rsp_len   = lenout;
  assign rsp_data  = dataout;
  assign occ       = occ_q;
  assign err       = err_q;
  assign hold_ack  = (state_q == ST_HALT);

  // Next occupancy, pointer, tag pipe and sticky error
  always_comb begin
    occ_d = occ_q;
    if (pushin)    occ_d = occ_d + 11'd32;
    if (grant_vld) occ_d = occ_d - {7'd0, reqlen};
    rr_ptr_d = rr_ptr_q;
    if (grant_vld) rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
    t1_vld_d = grant_vld;
    t1_id_d  = grant_id;
    t1_len_d = reqlen;
    t2_vld_d = t1_vld_q;
    t2_id_d  = t1_id_q;
    t2_len_d = t1_len_q;
    err_d    = err_q | (pushout != t2_vld_q) | (pushout && (lenout != t2_len_q));
  end

  // Hold handshake: stop granting, wait for the tag pipe to empty, then acknowledge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (hold) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (!t1_vld_q && !t2_vld_q) state_d = ST_HALT;
        else if (!hold)             state_d = ST_RUN;
      end
      ST_HALT:  if (!hold) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // State register; reset discards in-flight tags together with the FIFO
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      rr_ptr_q <= '0;
      occ_q    <= '0;
      t1_vld_q <= 1'b0;
      t1_id_q  <= '0;
      t1_len_q <= '0;
      t2_vld_q <= 1'b0;
      t2_id_q  <= '0;
      t2_len_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      occ_q    <= occ_d;
      t1_vld_q <= t1_vld_d;
      t1_id_q  <= t1_id_d;
      t1_len_q <= t1_len_d;
      t2_vld_q <= t2_vld_d;
      t2_id_q  <= t2_id_d;
      t2_len_q <= t2_len_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_bits_req_sched.sv
// tb/tb_bits_req_sched.sv - scoreboard bench for bits_req_sched with a behavioural bit FIFO
module tb_bits_req_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        src_valid = 1'b0;
  logic [31:0] src_data = '0;
  logic        src_ready;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_len = '0;
  logic [3:0]  req_ready;
  logic        hold = 1'b0;
  logic        hold_ack;
  logic        pushin;
  logic [31:0] datain;
  logic        reqin;
  logic [3:0]  reqlen;
  logic        pushout = 1'b0;
  logic [3:0]  lenout = '0;
  logic [14:0] dataout = '0;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_len;
  logic [14:0] rsp_data;
  logic [10:0] occ;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    int          len;
    logic [14:0] data;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  bits_req_sched #(.NREQ(4), .CAP_BITS(1024)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .hold(hold), .hold_ack(hold_ack),
    .pushin(pushin), .datain(datain), .reqin(reqin), .reqlen(reqlen),
    .pushout(pushout), .lenout(lenout), .dataout(dataout),
    .rsp_valid(rsp_valid), .rsp_len(rsp_len), .rsp_data(rsp_data),
    .occ(occ), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural bit FIFO: oldest bit first, response two cycles after the request
  bit          bq[$];
  logic        a_vld = 1'b0;
  logic [3:0]  a_len = '0;
  logic [14:0] a_data = '0;

  function automatic logic [14:0] pop_bits(input int n);
    logic [14:0] d = '0;
    for (int i = 0; i < n; i++) if (bq.size() > 0) d[i] = bq.pop_front();
    return d;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bq.delete();
      a_vld   <= 1'b0;
      a_len   <= '0;
      a_data  <= '0;
      pushout <= 1'b0;
      lenout  <= '0;
      dataout <= '0;
    end else begin
      if (pushin) for (int i = 0; i < 32; i++) bq.push_back(datain[i]);
      a_vld   <= reqin;
      a_len   <= reqlen;
      a_data  <= reqin ? pop_bits(int'(reqlen)) : 15'd0;
      pushout <= a_vld;
      lenout  <= a_len;
      dataout <= a_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: every response strobe is matched against the oldest expectation
  always @(negedge clk) begin
    if (rsp_valid != 4'd0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got rsp_valid=%b expected none (t=%0t)", rsp_valid, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << e.id);
        chk("rsp_len", 32'(rsp_len), 32'(e.len));
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        chk("rsp_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic expect_rsp(input int id, input int len, input logic [14:0] d);
    exp_t e;
    e.id = id; e.len = len; e.data = d; e.due = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int len);
    req_valid[i] = 1'b1;
    req_len[4*i +: 4] = 4'(len);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_valid = 1'b0;
    req_valid = '0;
    req_len = '0;
    hold = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) nxt();
    chk({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    // 1: single push then an 8-bit read
    do_reset();
    @(negedge clk);
    chk("rst_occ", 32'(occ), 32'd0);
    chk("rst_src_ready", 32'(src_ready), 32'd1);
    chk("rst_hold_ack", 32'(hold_ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    nxt();
    src_valid = 1'b1; src_data = 32'hA5A5_A5A5; set_req(0, 8);
    @(negedge clk);
    chk("t1_pushin", 32'(pushin), 32'd1);
    chk("t1_no_grant_push_cycle", 32'(req_ready), 32'd0);
    nxt();
    src_valid = 1'b0;
    @(negedge clk);
    chk("t1_grant", 32'(req_ready), 32'b0001);
    chk("t1_reqlen", 32'(reqlen), 32'd8);
    expect_rsp(0, 8, 15'h0A5);
    nxt();
    req_valid = '0;
    @(negedge clk);
    chk("t1_occ", 32'(occ), 32'd24);
    drain("t1");

    // 2: request against an empty buffer waits for the first push edge
    do_reset();
    set_req(1, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t2_empty_no_grant", 32'(req_ready), 32'd0);
      nxt();
    end
    src_valid = 1'b1; src_data = 32'h0000_0001;
    @(negedge clk);
    chk("t2_no_grant_push_cycle", 32'(req_ready), 32'd0);
    nxt();
    src_valid = 1'b0;
    @(negedge clk);
    chk("t2_grant", 32'(req_ready), 32'b0010);
    expect_rsp(1, 1, 15'h1);
    nxt();
    req_valid = '0;
    @(negedge clk);
    chk("t2_occ", 32'(occ), 32'd31);
    drain("t2");

    // 3: fill to capacity, space returns only once occ <= 992
    do_reset();
    for (int k = 0; k < 32; k++) begin
      src_valid = 1'b1;
      src_data = (k == 0) ? 32'h8765_4321 : (k == 1) ? 32'h0000_ABCD : 32'h0;
      @(negedge clk);
      if (k == 31) chk("t3_last_push_ready", 32'(src_ready), 32'd1);
      nxt();
    end
    src_data = 32'hDEAD_BEEF;
    set_req(2, 15);
    @(negedge clk);
    chk("t3_full_occ", 32'(occ), 32'd1024);
    chk("t3_full_ready", 32'(src_ready), 32'd0);
    chk("t3_full_pushin", 32'(pushin), 32'd0);
    chk("t3_rd1", 32'(req_ready), 32'b0100);
    expect_rsp(2, 15, 15'h4321);
    nxt();
    @(negedge clk);
    chk("t3_occ_1009", 32'(occ), 32'd1009);
    chk("t3_ready_1009", 32'(src_ready), 32'd0);
    chk("t3_rd2", 32'(req_ready), 32'b0100);
    expect_rsp(2, 15, 15'h0ECA);
    nxt();
    @(negedge clk);
    chk("t3_occ_994", 32'(occ), 32'd994);
    chk("t3_ready_994", 32'(src_ready), 32'd0);
    chk("t3_rd3", 32'(req_ready), 32'b0100);
    expect_rsp(2, 15, 15'h2F36);
    nxt();
    req_valid = '0;
    @(negedge clk);
    chk("t3_occ_979", 32'(occ), 32'd979);
    chk("t3_ready_979", 32'(src_ready), 32'd1);
    chk("t3_pushin_979", 32'(pushin), 32'd1);
    nxt();
    src_valid = 1'b0;
    @(negedge clk);
    chk("t3_occ_1011", 32'(occ), 32'd1011);
    drain("t3");

    // 4: all requesters contend, grants rotate 0..3
    do_reset();
    src_valid = 1'b1; src_data = 32'h7654_3210;
    nxt();
    src_data = 32'hFEDC_BA98;
    nxt();
    src_valid = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 4);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("t4_occ", 32'(occ), 32'(64 - 4 * k));
      chk("t4_grant", 32'(req_ready), 32'(1) << (k % 4));
      expect_rsp(k % 4, 4, 15'(k));
      nxt();
    end
    @(negedge clk);
    chk("t4_drained_occ", 32'(occ), 32'd0);
    chk("t4_drained_no_grant", 32'(req_ready), 32'd0);
    req_valid = '0;
    drain("t4");

    // 5: hold after a grant drains the pipe, then resumes
    do_reset();
    src_valid = 1'b1; src_data = 32'h0000_0F0F;
    nxt();
    src_valid = 1'b0;
    set_req(3, 5);
    @(negedge clk);
    chk("t5_grant", 32'(req_ready), 32'b1000);
    expect_rsp(3, 5, 15'h0F);
    nxt();
    hold = 1'b1;
    @(negedge clk);
    chk("t5_hold_no_grant", 32'(req_ready), 32'd0);
    chk("t5_ack_low1", 32'(hold_ack), 32'd0);
    nxt();
    @(negedge clk);
    chk("t5_inflight_rsp", 32'(rsp_valid), 32'b1000);
    chk("t5_ack_low2", 32'(hold_ack), 32'd0);
    chk("t5_drain_no_grant", 32'(req_ready), 32'd0);
    nxt();
    @(negedge clk);
    chk("t5_ack_low3", 32'(hold_ack), 32'd0);
    nxt();
    @(negedge clk);
    chk("t5_ack_high", 32'(hold_ack), 32'd1);
    chk("t5_halt_no_grant", 32'(req_ready), 32'd0);
    nxt();
    hold = 1'b0;
    @(negedge clk);
    chk("t5_ack_still_high", 32'(hold_ack), 32'd1);
    chk("t5_halt_exit_no_grant", 32'(req_ready), 32'd0);
    nxt();
    @(negedge clk);
    chk("t5_ack_released", 32'(hold_ack), 32'd0);
    chk("t5_resume_grant", 32'(req_ready), 32'b1000);
    expect_rsp(3, 5, 15'h18);
    nxt();
    req_valid = '0;
    drain("t5");

    // 6: simultaneous push and read, then reset with a read in flight
    do_reset();
    src_valid = 1'b1; src_data = 32'hFFFF_FFFF;
    repeat (4) nxt();
    src_valid = 1'b0;
    set_req(0, 14);
    @(negedge clk);
    chk("t6_rd1", 32'(req_ready), 32'b0001);
    expect_rsp(0, 14, 15'h3FFF);
    nxt();
    @(negedge clk);
    chk("t6_rd2", 32'(req_ready), 32'b0001);
    expect_rsp(0, 14, 15'h3FFF);
    nxt();
    set_req(0, 15); src_valid = 1'b1;
    @(negedge clk);
    chk("t6_occ_100", 32'(occ), 32'd100);
    chk("t6_rd3", 32'(req_ready), 32'b0001);
    chk("t6_push", 32'(pushin), 32'd1);
    expect_rsp(0, 15, 15'h7FFF);
    nxt();
    src_valid = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("t6_occ_117", 32'(occ), 32'd117);
    #1 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_occ", 32'(occ), 32'd0);
    chk("t6_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    chk("t6_rst_no_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    chk("t6_post_rst_occ", 32'(occ), 32'd0);
    nxt();
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
